bus_writer_module: RTL

- Source-side counterpart of the bus_register read port: a producer pushes words into a small FIFO, and the block presents the head word on one source slot of the shared source bus.
- A bus reader pops the head when its selector addresses this slot and it asserts acknowledge.
- Decouples producer timing from reader timing. Sits between a functional unit's result and the shared source bus.

---
 rtl/bus_writer_module_pkg.sv | 32 +++
 rtl/bus_writer_module_storage.sv | 37 +++
 rtl/bus_writer_module.sv | 118 +++++++++++
 3 files changed

// File: rtl/bus_writer_module_pkg.sv
// bus_writer_module_pkg
//   Shared definitions for the bus writer slice.
//   - `BIT_WIDTH          : word width of the shared source bus
//   - `SELECTOR_WIDTH(n)  : selector width for a bus with n source slots
//                           (slot 0 is reserved for "nothing selected"),
//                           shared with bus_register
//   - fifo_op_e           : per-cycle FIFO operation (push/pop combination)
//   Optional feature macro used by the slice: BUS_WRITER_HOLD_EN.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef SELECTOR_WIDTH
`define SELECTOR_WIDTH(count) $clog2((count) + 1)
`endif

package bus_writer_module_pkg;

  localparam int BUS_WIDTH = `BIT_WIDTH;

  // Encoded as {push, pop} so the top can build it by concatenation.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bus_writer_module_storage.sv
// bus_fifo_storage
//   depth x `BIT_WIDTH register array backing the bus writer FIFO.
//   Synchronous write, asynchronous (combinational) read. No reset: the
//   contents are only ever observed through entries the pointers mark live.
// Ports:
//   clock         rising-edge clock
//   write_enable  write write_data into write_address at the edge
//   write_address entry to write
//   write_data    word to store
//   read_address  entry to read
//   read_data     storage[read_address], combinational
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif

module bus_fifo_storage
  import bus_writer_module_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                       clock,
  input  logic                       write_enable,
  input  logic [$clog2(depth)-1:0]   write_address,
  input  logic [BUS_WIDTH-1:0]       write_data,
  input  logic [$clog2(depth)-1:0]   read_address,
  output logic [BUS_WIDTH-1:0]       read_data
);

  logic [depth-1:0][BUS_WIDTH-1:0] mem;

  always_ff @(posedge clock) begin
    if (write_enable) mem[write_address] <= write_data;
  end

  assign read_data = mem[read_address];

endmodule

// File: rtl/bus_writer_module.sv
// bus_writer_module
//   Source-side FIFO for one slot of the shared source bus. A producer pushes
//   words; the head word is presented on `source`, and a reader pops it by
//   selecting this slot and asserting read_acknowledge.
// Parameters:
//   count  number of source slots on the bus (selector = $clog2(count+1) bits)
//   slot   this block's selector value, 1..count (0 = nothing selected)
//   depth  FIFO entries, power of two, >= 2
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   write_enable      producer push request (ignored while full)
//   write_data        producer word
//   full              FIFO holds depth entries
//   selector          reader's current slot select
//   read_acknowledge  reader consumes the selected word this cycle
//   source            head word (0, or last popped word with hold, when empty)
//   valid             FIFO not empty
//   level             current occupancy
//   overflow          sticky: a push was attempted while full
// Optional feature:
//   BUS_WRITER_HOLD_EN  when defined, source holds the last popped word while
//                       the FIFO is empty instead of returning to 0.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef SELECTOR_WIDTH
`define SELECTOR_WIDTH(count) $clog2((count) + 1)
`endif

module bus_writer_module
  import bus_writer_module_pkg::*;
#(
  parameter int count = 1,
  parameter int slot  = 1,
  parameter int depth = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               write_enable,
  input  logic [`BIT_WIDTH-1:0]              write_data,
  output logic                               full,
  input  logic [`SELECTOR_WIDTH(count)-1:0]  selector,
  input  logic                               read_acknowledge,
  output logic [`BIT_WIDTH-1:0]              source,
  output logic                               valid,
  output logic [$clog2(depth):0]             level,
  output logic                               overflow
);

  localparam int PW = $clog2(depth);
  localparam int LW = PW + 1;
  localparam int SW = `SELECTOR_WIDTH(count);

  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level_q;
  logic                 ovf_q;
  logic                 push, pop;
  logic [BUS_WIDTH-1:0] head;
  fifo_op_e             op;

  // Flags come straight from occupancy; a depth-entry FIFO needs the extra
  // level bit to tell full from empty when the pointers coincide.
  assign full  = (level_q == LW'(depth));
  assign valid = (level_q != '0);
  assign level = level_q;
  assign overflow = ovf_q;

  // Full gates the push even when a pop frees a slot in the same cycle;
  // valid gates the pop even when a push fills the FIFO in the same cycle.
  assign push = write_enable && !full;
  assign pop  = read_acknowledge && (selector == SW'(slot)) && valid;
  assign op   = fifo_op_e'({push, pop});

  bus_fifo_storage #(.depth(depth)) u_storage (
    .clock         (clock),
    .write_enable  (push),
    .write_address (wr_ptr),
    .write_data    (write_data),
    .read_address  (rd_ptr),
    .read_data     (head)
  );

  // Pointers wrap by natural overflow (depth is a power of two).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (op)
        OP_PUSH: level_q <= level_q + 1'b1;
        OP_POP:  level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (write_enable && full) ovf_q <= 1'b1;
    end
  end

`ifdef BUS_WRITER_HOLD_EN
  // Remembers the word most recently taken by a reader so the slot keeps
  // showing it once the FIFO drains.
  logic [BUS_WIDTH-1:0] hold_q;

  always_ff @(posedge clock) begin
    if (reset)    hold_q <= '0;
    else if (pop) hold_q <= head;
  end

  assign source = valid ? head : hold_q;
`else
  // Storage is never reset, so the empty case must be forced to 0.
  assign source = valid ? head : '0;
`endif

endmodule
